// File: rtl/astro_game_sequencer_pkg.sv
// Shared types, widths and the saturating BCD score adder for the Astro Barrier game.
package astro_pkg;

  localparam int unsigned SHOT_W  = 4;
  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_SHOT  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OVER  = 3'd5,
    ST_WIN   = 3'd6
  } gameState_t;

  typedef logic [3:0] bcdDigit_t;

  // Adds a small count (0..9) to a two-digit BCD score, clamping at 99.
  function automatic logic [SCORE_W-1:0] bcdAdd(input logic [SCORE_W-1:0] cur,
                                                 input logic [3:0] inc);
    logic [4:0] onesSum;
    logic [4:0] tensSum;
    bcdDigit_t  onesOut;
    bcdDigit_t  tensOut;
    onesSum = 5'(cur[3:0]) + 5'(inc);
    tensSum = 5'(cur[7:4]);
    if (onesSum > 5'd9) begin
      onesSum = onesSum - 5'd10;
      tensSum = tensSum + 5'd1;
    end
    if (tensSum > 5'd9) begin
      return 8'h99;
    end
    onesOut = onesSum[3:0];
    tensOut = tensSum[3:0];
    return {tensOut, onesOut};
  endfunction

endpackage

// File: rtl/astro_game_sequencer_tick_gen.sv
// Free-running divider producing a registered one-cycle pulse every DIV clocks.
module astro_tick_gen #(
  parameter int unsigned DIV = 2097152
) (
  input  logic board_clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  // Count 0..DIV-1 and pulse on the cycle after the terminal count.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/astro_game_sequencer.sv
// Game-flow controller: level sequencing, shot budget, fire grants, hit tracking and BCD score.
module astro_game_sequencer
  import astro_pkg::*;
#(
  parameter int unsigned NUM_TARGETS     = 2,
  parameter int unsigned SHOTS_PER_LEVEL = 6,
  parameter int unsigned NUM_LEVELS      = 4,
  parameter int unsigned TICK_DIV        = 2097152,
  parameter int unsigned PAUSE_TICKS     = 32
) (
  input  logic                     board_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     fire_req,
  input  logic [NUM_TARGETS-1:0]   hit,
  input  logic                     shot_over,
  output logic                     game_tick,
  output logic                     fire_grant,
  output logic                     level_load,
  output logic [LEVEL_W-1:0]       level,
  output logic [SHOT_W-1:0]        shots_left,
  output logic [NUM_TARGETS-1:0]   hit_mask,
  output logic [SCORE_W-1:0]       score,
  output logic [STATE_W-1:0]       state
);

  localparam int unsigned PAUSE_W = $clog2(PAUSE_TICKS + 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_TICKS - 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [SHOT_W-1:0]  SHOT_LOAD  = SHOT_W'(SHOTS_PER_LEVEL);

  gameState_t curState;
  logic [PAUSE_W-1:0] pauseCnt;

  logic startS1, startS2, startS3;
  logic fireS1, fireS2, fireS3;
  logic startRise, startFall, fireRise;

  logic [NUM_TARGETS-1:0] newHits;
  logic [NUM_TARGETS-1:0] nextMask;
  logic [3:0]             newCount;
  logic                   shotEvent;

  assign state = curState;

  // Slow pacing tick shared with the sprite datapath.
  astro_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .board_clk (board_clk),
    .reset     (reset),
    .tick      (game_tick)
  );

  // Two-flop synchronizers plus a delay flop for edge detection.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      {startS1, startS2, startS3} <= 3'b000;
      {fireS1, fireS2, fireS3}    <= 3'b000;
    end else begin
      {startS1, startS2, startS3} <= {start, startS1, startS2};
      {fireS1, fireS2, fireS3}    <= {fire_req, fireS1, fireS2};
    end
  end

  assign startRise = startS2 & ~startS3;
  assign startFall = ~startS2 & startS3;
  assign fireRise  = fireS2 & ~fireS3;

  // Newly destroyed targets this shot and how many points they are worth.
  always_comb begin
    newHits   = hit & ~hit_mask;
    nextMask  = hit_mask | newHits;
    shotEvent = (|hit) | shot_over;
    newCount  = 4'd0;
    for (int i = 0; i < int'(NUM_TARGETS); i++) begin
      newCount = newCount + 4'(newHits[i]);
    end
  end

  // Game FSM with registered outputs; a start fall aborts from any active state.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      curState   <= ST_IDLE;
      level      <= '0;
      shots_left <= '0;
      hit_mask   <= '0;
      score      <= '0;
      fire_grant <= 1'b0;
      level_load <= 1'b0;
      pauseCnt   <= '0;
    end else begin
      fire_grant <= 1'b0;
      level_load <= 1'b0;
      if (curState != ST_IDLE && startFall) begin
        curState <= ST_IDLE;
      end else begin
        case (curState)
          ST_IDLE: begin
            if (startRise) begin
              level    <= '0;
              score    <= '0;
              curState <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            level_load <= 1'b1;
            shots_left <= SHOT_LOAD;
            hit_mask   <= '0;
            curState   <= ST_PLAY;
          end
          ST_PLAY: begin
            if (fireRise && shots_left != '0) begin
              fire_grant <= 1'b1;
              shots_left <= shots_left - SHOT_W'(1);
              curState   <= ST_SHOT;
            end
          end
          ST_SHOT: begin
            if (shotEvent) begin
              hit_mask <= nextMask;
              score    <= bcdAdd(score, newCount);
              pauseCnt <= '0;
              if (&nextMask) begin
                curState <= ST_CLEAR;
              end else if (shots_left == '0) begin
                curState <= ST_OVER;
              end else begin
                curState <= ST_PLAY;
              end
            end
          end
          ST_CLEAR: begin
            if (game_tick) begin
              if (pauseCnt == PAUSE_LAST) begin
                pauseCnt <= '0;
                if (level == LAST_LEVEL) begin
                  curState <= ST_WIN;
                end else begin
                  level    <= level + LEVEL_W'(1);
                  curState <= ST_LOAD;
                end
              end else begin
                pauseCnt <= pauseCnt + PAUSE_W'(1);
              end
            end
          end
          ST_OVER, ST_WIN: begin
            curState <= curState;
          end
          default: begin
            curState <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/astro_game_sequencer.md
# astro_game_sequencer

Game-flow controller for the Astro Barrier VGA game. It sequences levels, owns the per-level shot budget, grants bullet launches, and tracks which targets are destroyed and the BCD score. It also produces the slow game tick that paces sprite motion. It sits between the debounced buttons/switches and the sprite/bullet datapath. The datapath moves objects only on `game_tick`, launches only on `fire_grant`, and reloads targets on `level_load`.

## Interface
Parameters:
- `NUM_TARGETS`, 2: targets per level (1..9).
- `SHOTS_PER_LEVEL`, 6: bullets per level (1..15).
- `NUM_LEVELS`, 4: levels to win (1..4).
- `TICK_DIV`, 2097152: `board_clk` cycles per `game_tick`.
- `PAUSE_TICKS`, 32: game ticks spent in level-clear pause.

Ports:
- `board_clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: game switch, asynchronous level.
- `fire_req` in 1: fire button, asynchronous level.
- `hit` in NUM_TARGETS: one-cycle pulse per target struck by the bullet.
- `shot_over` in 1: one-cycle pulse when the bullet leaves the top of the screen.
- `game_tick` out 1: one-cycle pulse every TICK_DIV cycles.
- `fire_grant` out 1: one-cycle pulse that launches a bullet.
- `level_load` out 1: one-cycle pulse that reloads target positions.
- `level` out 2: current level, 0-based.
- `shots_left` out 4: remaining bullets.
- `hit_mask` out NUM_TARGETS: bit i is set when target i has been destroyed this level.
- `score` out 8: two BCD digits, {tens, ones}.
- `state` out 3: FSM state code for the LEDs.

## Operation
- `start` and `fire_req` each pass through a 2-flop synchronizer, followed by a delay flop. Rise is `s2 & ~s3`; fall is `~s2 & s3`.
- Tick counter:
  - Runs freely from 0 to TICK_DIV-1, then wraps.
  - `game_tick` is registered and high for the one cycle after the count equals TICK_DIV-1.
- FSM states: IDLE=0, LOAD=1, PLAY=2, SHOT=3, CLEAR=4, OVER=5, WIN=6.
- IDLE, on `start` rise: `level`<=0, `score`<=0, go to LOAD.
- LOAD (one cycle): pulse `level_load`, set `shots_left`<=SHOTS_PER_LEVEL and `hit_mask`<=0, go to PLAY.
- PLAY, on `fire_req` rise with `shots_left`>0: pulse `fire_grant`, decrement `shots_left`, go to SHOT.
  - A rise with `shots_left`==0 is ignored; this is unreachable in PLAY.
  - `hit` and `shot_over` are ignored in PLAY.
- SHOT, on a cycle with any `hit` or `shot_over`:
  - new = `hit & ~hit_mask`; `hit_mask` |= new; `score` += popcount(new) in BCD.
  - `score` saturates at 99.
  - Then evaluate the level in this priority order:
    - If the next mask is all ones, go to CLEAR.
    - Else if `shots_left`==0, go to OVER.
    - Else go to PLAY.
  - `hit` together with `shot_over` in the same cycle counts as one evaluation; the hit is scored.
  - `fire_req` rises in SHOT are dropped, not queued.
- CLEAR:
  - Counts `game_tick` pulses.
  - On the PAUSE_TICKS-th tick: go to WIN if `level`==NUM_LEVELS-1; otherwise `level`+1 and go to LOAD.
- OVER / WIN: outputs hold. On `start` fall, go to IDLE; `score` and `level` are held for display.
- `start` fall in any other state: go to IDLE immediately. This aborts the game; no pulses are emitted.
- `reset`, asynchronous, at any time:
  - State IDLE.
  - All counters, synchronizer flops and outputs become 0, except `shots_left`=0 and `hit_mask`=0.
  - This applies mid-game, during SHOT, and during CLEAR.

## Timing
- All outputs are registered. `level_load`, `fire_grant` and `game_tick` are exactly one cycle wide.
- Input latency: if `fire_req` or `start` is first sampled high at edge N, the rise is seen at edge N+2.
  - `fire_grant`/`level_load`: the LOAD state is entered at N+2 and `level_load` asserts at N+3.
  - `fire_grant` is high from edge N+2 to N+3.
- SHOT evaluation is single-cycle. `state`, `hit_mask` and `score` update on the edge that samples `hit`/`shot_over`.
- Between `start` rise and the first possible `fire_grant`: 2 cycles (LOAD, then PLAY).
- Score arithmetic:
  - Ones digit: add, and if the result is >9, subtract 10 and carry 1.
  - Tens digit: if it would exceed 9, clamp both digits to 9.

## Structure
- Shared package `astro_pkg` holds:
  - State encodings `ST_IDLE`..`ST_WIN`.
  - `SHOT_W`=4, `LEVEL_W`=2, `SCORE_W`=8.
  - BCD digit type.
- Sub-module `astro_tick_gen` (TICK_DIV counter plus registered pulse). It is also reused by the SSD scan logic.
- The synchronizers and the BCD adder stay inline.

## Test plan
- Reset mid-SHOT:
  - Stimulus: `reset` asserted while in SHOT with `shots_left`=3 and `score`=0x05.
  - Response: `state`=0, `shots_left`=0, `score`=0, and no `fire_grant` until `start` rises again.
- Clear level 0:
  - Stimulus: `start` rise, fire, `hit`=2'b01; fire, `hit`=2'b10.
  - Response: `score`=0x02, `shots_left`=4, CLEAR.
  - After 32 ticks (TICK_DIV=4 in the bench): `level`=1 and one `level_load` pulse.
- Lose a level: six `shot_over` with no hits leads to OVER, with `shots_left`=0. A seventh `fire_req` produces no grant.
- Simultaneous double hit:
  - Stimulus: `hit`=2'b11 and `shot_over` in the same cycle.
  - Response: `score`+2, CLEAR.
  - A repeated hit on a masked target adds 0.
- BCD boundary: the score passes 0x09 to 0x10 correctly, and a preload of 0x98 plus a double hit gives 0x99.
- Full game win: four levels cleared leads to WIN with `level`=3. A `start` fall then returns to IDLE with the score held.
